// File: rtl/pc_sequencer.sv
// Four-state instruction sequencer: fetches from a 16-entry instruction memory,
// decodes a 2-bit opcode and steps the program counter, halting on timeout or HALT.
module pc_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       imem_req,
    output logic [3:0] imem_addr,
    input  logic       imem_ack,
    input  logic [7:0] imem_data,
    input  logic       eq_flag,
    input  logic       ex_busy,
    output logic [3:0] pc,
    output logic [7:0] inst,
    output logic       inst_valid,
    output logic       wb_en,
    output logic       halted,
    output logic       fetch_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_pc;
    logic [3:0] w_pc_nxt;
    logic [3:0] w_pc_inc;
    logic [7:0] r_inst;
    logic [7:0] w_inst_nxt;
    logic [7:0] r_wait;
    logic [7:0] w_wait_nxt;
    logic [7:0] w_wait_inc;
    logic       r_fetch_err;
    logic       w_fetch_err_nxt;
    logic       w_wb_en;

    assign w_pc_inc   = r_pc + 4'd1;
    assign w_wait_inc = r_wait + 8'd1;

    // State, program counter, instruction latch, wait counter and error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_pc        <= 4'd0;
            r_inst      <= 8'h00;
            r_wait      <= 8'd0;
            r_fetch_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_inst      <= w_inst_nxt;
            r_wait      <= w_wait_nxt;
            r_fetch_err <= w_fetch_err_nxt;
        end
    end

    // Next-state logic, decode and the write-back strobe.
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_inst_nxt      = r_inst;
        w_wait_nxt      = r_wait;
        w_fetch_err_nxt = r_fetch_err;
        w_wb_en         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_HALT: begin
                if (start) begin
                    w_state_nxt     = ST_FETCH;
                    w_pc_nxt        = 4'd0;
                    w_fetch_err_nxt = 1'b0;
                end else begin
                    w_state_nxt = ST_HALT;
                end
            end
            ST_FETCH: begin
                // An ack in the cycle the timeout would expire still wins.
                if (imem_ack) begin
                    w_inst_nxt  = imem_data;
                    w_wait_nxt  = 8'd0;
                    w_state_nxt = ST_EXEC;
                end else if (w_wait_inc == TIMEOUT_LIMIT) begin
                    w_wait_nxt      = 8'd0;
                    w_fetch_err_nxt = 1'b1;
                    w_state_nxt     = ST_HALT;
                end else begin
                    w_wait_nxt = w_wait_inc;
                end
            end
            ST_EXEC: begin
                if (ex_busy) begin
                    w_state_nxt = ST_EXEC;
                end else begin
                    w_state_nxt = ST_FETCH;
                    case (r_inst[7:6])
                        2'b00: begin
                            w_pc_nxt = w_pc_inc;
                            w_wb_en  = |r_inst;
                        end
                        2'b01: begin
                            w_pc_nxt = w_pc_inc;
                            w_wb_en  = 1'b1;
                        end
                        2'b10: begin
                            if (eq_flag) begin
                                w_pc_nxt = r_inst[3:0];
                            end else begin
                                w_pc_nxt = w_pc_inc;
                            end
                        end
                        2'b11: begin
                            w_state_nxt = ST_HALT;
                        end
                        default: begin
                            w_state_nxt = ST_IDLE;
                        end
                    endcase
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign imem_req   = (r_state == ST_FETCH);
    assign imem_addr  = r_pc;
    assign pc         = r_pc;
    assign inst       = r_inst;
    assign inst_valid = (r_state == ST_EXEC);
    assign halted     = (r_state == ST_HALT);
    assign fetch_err  = r_fetch_err;
    assign wb_en      = w_wb_en;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       imem_req;
    logic [3:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_data;
    logic       eq_flag;
    logic       ex_busy;
    logic [3:0] pc;
    logic [7:0] inst;
    logic       inst_valid;
    logic       wb_en;
    logic       halted;
    logic       fetch_err;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(.TIMEOUT_CYCLES(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .eq_flag    (eq_flag),
        .ex_busy    (ex_busy),
        .pc         (pc),
        .inst       (inst),
        .inst_valid (inst_valid),
        .wb_en      (wb_en),
        .halted     (halted),
        .fetch_err  (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction with ack for a single FETCH cycle.
    task automatic feed(input logic [7:0] data);
        imem_ack  = 1'b1;
        imem_data = data;
        step();
        imem_ack  = 1'b0;
        imem_data = 8'h00;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pc"}, {12'd0, pc}, 16'd0);
        chk({tag, "_inst"}, {8'd0, inst}, 16'd0);
        chk({tag, "_outs"}, {11'd0, imem_req, inst_valid, wb_en, halted, fetch_err}, 16'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; imem_data = 8'h00;
        eq_flag = 1'b0; ex_busy = 1'b0;
        #3;
        chk_all_zero("reset");
        step();
        rst_n = 1'b1;
        step();
        chk("idle_no_req", {15'd0, imem_req}, 16'd0);

        // ADD 8'h12 fetched from pc 0
        start = 1'b1;
        step();
        start = 1'b0;
        chk("fetch0_req", {15'd0, imem_req}, 16'd1);
        chk("fetch0_addr", {12'd0, imem_addr}, 16'd0);
        feed(8'h12);
        chk("add_valid", {15'd0, inst_valid}, 16'd1);
        chk("add_inst", {8'd0, inst}, 16'h0012);
        chk("add_wb", {15'd0, wb_en}, 16'd1);
        step();
        chk("add_valid_drop", {14'd0, inst_valid, wb_en}, 16'd0);
        chk("add_pc", {12'd0, pc}, 16'd1);
        chk("add_refetch", {11'd0, imem_req, imem_addr}, 16'h0011);

        // NOP at pc 1 -> pc 2, no write-back
        feed(8'h00);
        chk("nop_wb", {15'd0, wb_en}, 16'd0);
        step();
        chk("nop_pc", {12'd0, pc}, 16'd2);

        // BEQ 8'h89 taken at pc 2
        eq_flag = 1'b1;
        feed(8'h89);
        chk("beq_t_wb", {15'd0, wb_en}, 16'd0);
        step();
        chk("beq_t_pc", {12'd0, pc}, 16'd9);
        feed(8'h82);
        step();
        chk("beq_back_pc", {12'd0, pc}, 16'd2);
        // BEQ 8'h89 not taken at pc 2
        eq_flag = 1'b0;
        feed(8'h89);
        chk("beq_nt_wb", {15'd0, wb_en}, 16'd0);
        step();
        chk("beq_nt_pc", {12'd0, pc}, 16'd3);

        // jump to pc F, then NOP wraps pc to 0
        eq_flag = 1'b1;
        feed(8'h8F);
        step();
        eq_flag = 1'b0;
        chk("to_f_pc", {12'd0, pc}, 16'hF);
        feed(8'h00);
        step();
        chk("wrap_pc", {12'd0, pc}, 16'd0);
        chk("wrap_fetch", {14'd0, imem_req, halted}, 16'b10);

        // LI stalled by ex_busy for 3 cycles
        ex_busy = 1'b1;
        feed(8'h45);
        for (int i = 0; i < 3; i++) begin
            chk("li_busy_wb", {14'd0, inst_valid, wb_en}, 16'b10);
            chk("li_busy_pc", {12'd0, pc}, 16'd0);
            chk("li_busy_inst", {8'd0, inst}, 16'h0045);
            if (i < 2) step();
        end
        step();
        ex_busy = 1'b0;
        #1;
        chk("li_release_wb", {14'd0, inst_valid, wb_en}, 16'b11);
        step();
        chk("li_pc", {12'd0, pc}, 16'd1);
        chk("li_after_wb", {15'd0, wb_en}, 16'd0);

        // start ignored while fetching
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_ign", {11'd0, imem_req, pc}, 16'h0011);

        // BEQ to pc 5, then HALT opcode
        eq_flag = 1'b1;
        feed(8'h85);
        step();
        eq_flag = 1'b0;
        chk("to5_pc", {12'd0, pc}, 16'd5);
        feed(8'hC0);
        chk("halt_op_wb", {15'd0, wb_en}, 16'd0);
        step();
        chk("halt_state", {13'd0, halted, imem_req, fetch_err}, 16'b100);
        chk("halt_pc", {12'd0, pc}, 16'd5);
        imem_ack = 1'b1; imem_data = 8'h12;
        step();
        imem_ack = 1'b0;
        chk("halt_ack_ign", {11'd0, halted, pc}, 16'h0015);

        // restart, ADD to pc 1, then ack on the 8th cycle (ack wins)
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_pc", {11'd0, imem_req, pc}, 16'h0010);
        feed(8'h12);
        step();
        repeat (7) step();
        chk("late_still_fetch", {14'd0, imem_req, halted}, 16'b10);
        feed(8'h00);
        chk("late_ack_exec", {14'd0, inst_valid, fetch_err}, 16'b10);
        step();
        chk("late_ack_pc", {12'd0, pc}, 16'd2);

        // timeout at pc 2
        repeat (7) step();
        chk("to_7_fetch", {14'd0, imem_req, halted}, 16'b10);
        step();
        chk("to_halt", {13'd0, halted, fetch_err, imem_req}, 16'b110);
        chk("to_pc", {12'd0, pc}, 16'd2);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("to_restart", {10'd0, imem_req, fetch_err, pc}, 16'h0020);

        // reset mid-FETCH
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_fetch");
        step();
        rst_n = 1'b1;
        step();
        chk("rst_stay_idle", {15'd0, imem_req}, 16'd0);

        // reset mid-EXEC with a pending write-back
        start = 1'b1;
        step();
        start = 1'b0;
        ex_busy = 1'b1;
        feed(8'h12);
        chk("busy_exec", {14'd0, inst_valid, wb_en}, 16'b10);
        #2;
        ex_busy = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_exec");
        step();
        rst_n = 1'b1;
        repeat (2) step();
        chk("rst_exec_idle", {14'd0, imem_req, inst_valid}, 16'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("resume_fetch", {11'd0, imem_req, pc}, 16'h0010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
